// File: rtl/regfile_mp.sv
// Multi-read-port register file with single write port, self-clearing init
// sequence after reset, x0 hardwired to zero and optional write-first forwarding.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRP    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  i_rden,
    input  logic [NRP*AW-1:0]     i_rs_addr,
    output logic [NRP*XLEN-1:0]   o_rs_data,
    output logic                  o_rd_vld,
    input  logic                  i_wren,
    input  logic [AW-1:0]         i_rdt_addr,
    input  logic [XLEN-1:0]       i_rdt_data,
    output logic                  o_busy,
    output logic                  o_wr_err
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state_reg;
    logic [AW-1:0]   ptr_reg;
    logic            wr_err_reg;
    logic            rd_vld_reg;
    logic            user_we;

    // No reset on the array so it can map onto block RAM; CLEAR initialises it.
    logic [XLEN-1:0] mem [NREG];

    assign user_we = i_wren && (i_rdt_addr != '0) && (state_reg == READY);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_reg  <= CLEAR;
            ptr_reg    <= AW'(1);
            wr_err_reg <= 1'b0;
            rd_vld_reg <= 1'b0;
        end else begin
            rd_vld_reg <= i_rden && (state_reg == READY);
            case (state_reg)
                CLEAR: begin
                    if (i_wren) begin
                        wr_err_reg <= 1'b1;
                    end
                    if (ptr_reg == AW'(NREG - 1)) begin
                        state_reg <= READY;
                    end
                    ptr_reg <= ptr_reg + AW'(1);
                end
                READY: begin
                    state_reg <= READY;
                end
                default: begin
                    state_reg <= CLEAR;
                end
            endcase
        end
    end

    // Single write port shared between the clear sweep and user writes.
    always_ff @(posedge clk) begin
        if (aresetn) begin
            if (state_reg == CLEAR) begin
                mem[ptr_reg] <= '0;
            end else if (user_we) begin
                mem[i_rdt_addr] <= i_rdt_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_rd
            logic [AW-1:0]   addr;
            logic            fwd;
            logic [XLEN-1:0] data_reg;

            assign addr = i_rs_addr[gi*AW +: AW];
            assign fwd  = (BYPASS != 0) && user_we && (i_rdt_addr == addr);

            always_ff @(posedge clk) begin
                if (!aresetn) begin
                    data_reg <= '0;
                end else if (state_reg == CLEAR) begin
                    data_reg <= '0;
                end else if (i_rden) begin
                    if (addr == '0) begin
                        data_reg <= '0;
                    end else if (fwd) begin
                        data_reg <= i_rdt_data;
                    end else begin
                        data_reg <= mem[addr];
                    end
                end
            end

            assign o_rs_data[gi*XLEN +: XLEN] = data_reg;
        end
    endgenerate

    assign o_busy   = (state_reg == CLEAR);
    assign o_wr_err = wr_err_reg;
    assign o_rd_vld = rd_vld_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one write-first and one read-first instance driven in
// lockstep, checked against an array-based model plus directed vectors.
module tb_regfile_mp;

    logic        clk;
    logic        rstn;
    logic        rden;
    logic [9:0]  rs_addr;
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    logic [63:0] data_a, data_b;
    logic        vld_a, vld_b, busy_a, busy_b, err_a, err_b;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(1)) dut (
        .clk(clk), .aresetn(rstn), .i_rden(rden), .i_rs_addr(rs_addr),
        .o_rs_data(data_a), .o_rd_vld(vld_a), .i_wren(wren),
        .i_rdt_addr(waddr), .i_rdt_data(wdata), .o_busy(busy_a), .o_wr_err(err_a)
    );

    regfile_mp #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(0)) dut_rf (
        .clk(clk), .aresetn(rstn), .i_rden(rden), .i_rs_addr(rs_addr),
        .o_rs_data(data_b), .o_rd_vld(vld_b), .i_wren(wren),
        .i_rdt_addr(waddr), .i_rdt_data(wdata), .o_busy(busy_b), .o_wr_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    // Reference model: a countdown for the clear phase and a plain array.
    int          busy_left;
    logic [31:0] mm [32];
    logic        m_err, m_vld;
    logic [31:0] m_a [2];
    logic [31:0] m_b [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [4:0] ra [2];
        ra[0] = rs_addr[4:0];
        ra[1] = rs_addr[9:5];
        if (!rstn) begin
            busy_left = 31;
            m_err     = 1'b0;
            m_vld     = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_a[p] = '0;
                m_b[p] = '0;
            end
        end else if (busy_left > 0) begin
            if (wren) m_err = 1'b1;
            busy_left--;
            if (busy_left == 0) begin
                foreach (mm[i]) mm[i] = '0;
            end
            m_vld = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_a[p] = '0;
                m_b[p] = '0;
            end
        end else begin
            m_vld = rden;
            if (rden) begin
                for (int p = 0; p < 2; p++) begin
                    if (ra[p] == 5'd0) begin
                        m_a[p] = '0;
                        m_b[p] = '0;
                    end else begin
                        m_b[p] = mm[ra[p]];
                        m_a[p] = (wren && waddr == ra[p]) ? wdata : mm[ra[p]];
                    end
                end
            end
            if (wren && waddr != 5'd0) mm[waddr] = wdata;
        end
        @(posedge clk);
        #1;
        chk("busy_byp",  64'(busy_a), 64'(busy_left > 0));
        chk("busy_rf",   64'(busy_b), 64'(busy_left > 0));
        chk("err_byp",   64'(err_a),  64'(m_err));
        chk("err_rf",    64'(err_b),  64'(m_err));
        chk("vld_byp",   64'(vld_a),  64'(m_vld));
        chk("vld_rf",    64'(vld_b),  64'(m_vld));
        chk("data_byp",  data_a, {m_a[1], m_a[0]});
        chk("data_rf",   data_b, {m_b[1], m_b[0]});
    endtask

    task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic re, input logic [4:0] r0, input logic [4:0] r1);
        wren    = we;
        waddr   = wa;
        wdata   = wd;
        rden    = re;
        rs_addr = {r1, r0};
    endtask

    task automatic do_reset();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        rstn = 1'b0;
        tick();
        tick();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  r0, r1;
        logic        vld;
        logic [31:0] a0, a1;
        logic [31:0] b0, b1;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n;
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7, 1'b1, 32'h12345678, 32'h12345678, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 1'b1, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 1'b0, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[6] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd5, 1'b1, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[8] = '{1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 5'd5, 5'd7, 1'b1, 32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        vecs[9] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};

        // Reset state and clear length, then every register reads zero.
        do_reset();
        chk("rst_busy", 64'(busy_a), 64'd1);
        chk("rst_err",  64'(err_a),  64'd0);
        chk("rst_vld",  64'(vld_a),  64'd0);
        chk("rst_data", data_a,      64'd0);
        rstn = 1'b1;
        count_busy(n);
        chk("busy_len", 64'(n), 64'd31);
        $display("[TB] clear after reset: busy for %0d cycles", n);
        for (int r = 1; r < 32; r += 2) begin
            set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), (r == 31) ? 5'd0 : 5'(r + 1));
            tick();
            chk("init_zero", data_a, 64'd0);
        end

        // Directed READY vectors.
        for (int v = 0; v < 10; v++) begin
            set_in(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].re, vecs[v].r0, vecs[v].r1);
            tick();
            chk("vec_vld", 64'(vld_a), 64'(vecs[v].vld));
            chk("vec_byp", data_a, {vecs[v].a1, vecs[v].a0});
            chk("vec_rf",  data_b, {vecs[v].b1, vecs[v].b0});
            chk("vec_err", 64'(err_a), 64'd0);
            $display("[TB] vec %0d: wr=%0d x%0d=%h rd=%0d x%0d,x%0d -> byp %h rf %h vld %0d",
                     v, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].re, vecs[v].r0, vecs[v].r1,
                     data_a, data_b, vld_a);
        end

        // Random traffic on a narrow address range to force collisions.
        for (int c = 0; c < 400; c++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end
        $display("[TB] random phase: 400 cycles against model");

        // Write attempted during clear cycle 3 is dropped and flagged.
        do_reset();
        rstn = 1'b1;
        tick();
        tick();
        set_in(1'b1, 5'd2, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        chk("clr_err_set", 64'(err_a), 64'd1);
        count_busy(n);
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd3);
        tick();
        chk("clr_drop", data_a, 64'd0);
        set_in(1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 5'd0);
        repeat (5) tick();
        chk("err_sticky", 64'(err_a), 64'd1);
        $display("[TB] write during clear: err=%0d x2=%h", err_a, data_a[31:0]);

        // Reset pulsed at clear cycle 10 restarts the full sweep and clears err.
        do_reset();
        rstn = 1'b1;
        repeat (4) tick();
        wren = 1'b1;
        tick();
        wren = 1'b0;
        repeat (4) tick();
        rstn = 1'b0;
        tick();
        chk("restart_busy", 64'(busy_a), 64'd1);
        rstn = 1'b1;
        count_busy(n);
        chk("restart_len", 64'(n), 64'd31);
        chk("restart_err", 64'(err_a), 64'd0);
        $display("[TB] reset mid-clear: busy for %0d cycles, err=%0d", n, err_a);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
